// File: rtl/yutorina_bus_if_if.sv
// External bus bundle between the MEM-stage bus interface (master) and the
// system bus (slave); all strobes are active-low.
interface yutorina_bus_if_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              bus_req_;
  logic              bus_grnt_;
  logic              bus_as_;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_rdy_;

  modport master (
    output bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
    input  bus_grnt_, bus_rd_data, bus_rdy_
  );

  modport slave (
    input  bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
    output bus_grnt_, bus_rd_data, bus_rdy_
  );
endinterface

// File: rtl/yutorina_bus_if.sv
// MEM-stage bus interface: arbitrates for the bus, runs one read/write cycle
// with a timeout, and holds load data while the pipeline is stalled.
module yutorina_bus_if #(
  parameter int TIMEOUT_CYC = 255,
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              as_,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              bus_err,
  yutorina_bus_if_if.master bus
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
  localparam logic       READ     = 1'b1;

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, STALL} state_t;

  state_t            state;
  logic [7:0]        cnt;
  logic [DATA_W-1:0] rd_buf;

  logic start;
  logic rdy;
  logic tmo;

  assign start = (state == IDLE) && !as_ && !flush;
  assign rdy   = (state == ACCESS) && !bus.bus_rdy_;
  // Ready in the last allowed cycle still counts as success.
  assign tmo   = (state == ACCESS) && bus.bus_rdy_ && (cnt == TMO_LAST);

  // bus_err is decoded from state so it pulses in the aborting cycle itself,
  // together with the released busy and zeroed rd_data.
  assign bus_err = tmo;

  always_comb begin
    busy    = 1'b0;
    rd_data = '0;
    case (state)
      IDLE:   busy = start;
      REQ:    busy = 1'b1;
      ACCESS: begin
        busy = bus.bus_rdy_ && !tmo;
        if (rdy && bus.bus_rw) rd_data = bus.bus_rd_data;
      end
      STALL:  rd_data = rd_buf;
      default: begin
        busy    = 1'b0;
        rd_data = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      bus.bus_req_    <= 1'b1;
      bus.bus_as_     <= 1'b1;
      bus.bus_rw      <= READ;
      bus.bus_addr    <= '0;
      bus.bus_wr_data <= '0;
      rd_buf          <= '0;
      cnt             <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bus.bus_req_ <= 1'b0;
            state        <= REQ;
          end
        end
        REQ: begin
          // Flush wins over a grant arriving in the same cycle.
          if (flush) begin
            bus.bus_req_ <= 1'b1;
            state        <= IDLE;
          end else if (!bus.bus_grnt_) begin
            bus.bus_as_     <= 1'b0;
            bus.bus_rw      <= rw;
            bus.bus_addr    <= addr;
            bus.bus_wr_data <= wr_data;
            cnt             <= '0;
            state           <= ACCESS;
          end
        end
        ACCESS: begin
          // Flush is deliberately ignored here: a started bus cycle must finish.
          bus.bus_as_ <= 1'b1;
          if (rdy) begin
            if (bus.bus_rw) rd_buf <= bus.bus_rd_data;
            bus.bus_req_ <= 1'b1;
            state        <= stall ? STALL : IDLE;
          end else if (tmo) begin
            rd_buf       <= '0;
            bus.bus_req_ <= 1'b1;
            state        <= stall ? STALL : IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        STALL: begin
          if (!stall || flush) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_yutorina_bus_if.sv
// Directed bench for yutorina_bus_if, built with a 4-cycle bus timeout.
module tb_yutorina_bus_if;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, as_, rw;
  logic [29:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        busy, bus_err;
  int          checks = 0;
  int          errors = 0;

  yutorina_bus_if_if bi ();

  yutorina_bus_if #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .as_(as_), .rw(rw),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .busy(busy),
    .bus_err(bus_err), .bus(bi.master)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 0; flush = 0; as_ = 1; rw = 1; addr = '0; wr_data = '0;
    bi.bus_grnt_ = 1; bi.bus_rdy_ = 1; bi.bus_rd_data = '0;
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bi.bus_req_, bi.bus_as_, bi.bus_rw} !== 3'b111) begin
      errors++; $display("FAIL reset_strobes got %b want 111", {bi.bus_req_, bi.bus_as_, bi.bus_rw});
    end
    checks++;
    if (bi.bus_addr !== 30'd0 || bi.bus_wr_data !== 32'd0) begin
      errors++; $display("FAIL reset_cmd got addr %h data %h want 0 0", bi.bus_addr, bi.bus_wr_data);
    end
    checks++;
    if (busy !== 1'b0 || bus_err !== 1'b0 || rd_data !== 32'd0) begin
      errors++; $display("FAIL reset_outs got busy %b err %b rd %h want 0 0 0", busy, bus_err, rd_data);
    end
    next_cycle();
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_read();
    int busy_cnt = 0;
    int as_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      as_ = (i <= 4) ? 1'b0 : 1'b1; rw = 1; addr = 30'h10;
      bi.bus_grnt_ = (i == 2) ? 1'b0 : 1'b1;
      bi.bus_rdy_ = (i == 4) ? 1'b0 : 1'b1;
      bi.bus_rd_data = (i == 4) ? 32'hDEADBEEF : 32'h0;
      @(negedge clk);
      busy_cnt += int'(busy);
      as_cnt += int'(!bi.bus_as_);
      if (i == 1) begin
        checks++;
        if (bi.bus_req_ !== 1'b0 || rd_data !== 32'd0) begin
          errors++; $display("FAIL read_req got req_ %b rd %h want 0 0", bi.bus_req_, rd_data);
        end
      end
      if (i == 3) begin
        checks++;
        if (bi.bus_as_ !== 1'b0 || bi.bus_addr !== 30'h10 || bi.bus_rw !== 1'b1) begin
          errors++; $display("FAIL read_cmd got as_ %b addr %h rw %b want 0 10 1", bi.bus_as_, bi.bus_addr, bi.bus_rw);
        end
      end
      if (i == 4) begin
        checks++;
        if (rd_data !== 32'hDEADBEEF || busy !== 1'b0 || bus_err !== 1'b0) begin
          errors++; $display("FAIL read_data got rd %h busy %b err %b want deadbeef 0 0", rd_data, busy, bus_err);
        end
      end
      if (i == 5) begin
        checks++;
        if (bi.bus_req_ !== 1'b1 || rd_data !== 32'd0 || bi.bus_addr !== 30'h10) begin
          errors++; $display("FAIL read_done got req_ %b rd %h addr %h want 1 0 10", bi.bus_req_, rd_data, bi.bus_addr);
        end
      end
      next_cycle();
    end
    checks++;
    if (busy_cnt !== 4) begin errors++; $display("FAIL read_busy_cycles got %0d want 4", busy_cnt); end
    checks++;
    if (as_cnt !== 1) begin errors++; $display("FAIL read_as_cycles got %0d want 1", as_cnt); end
  endtask

  task automatic test_write();
    as_ = 0; rw = 0; addr = 30'h2A; wr_data = 32'h12345678;
    bi.bus_grnt_ = 0; bi.bus_rdy_ = 0; bi.bus_rd_data = 32'hFFFF0000;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL write_idle_busy got %b want 1", busy); end
    next_cycle();
    next_cycle();
    stall = 1;
    @(negedge clk);
    checks++;
    if (bi.bus_wr_data !== 32'h12345678 || bi.bus_rw !== 1'b0 || bi.bus_as_ !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL write_cmd got data %h rw %b as_ %b busy %b want 12345678 0 0 0",
                         bi.bus_wr_data, bi.bus_rw, bi.bus_as_, busy);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rd_data !== 32'hDEADBEEF || bi.bus_req_ !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL write_rdbuf got rd %h req_ %b busy %b want deadbeef 1 0", rd_data, bi.bus_req_, busy);
    end
    stall = 0; as_ = 1; bi.bus_grnt_ = 1; bi.bus_rdy_ = 1; bi.bus_rd_data = '0;
    next_cycle();
  endtask

  task automatic test_stall_hold();
    int as_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      as_ = (i >= 5) ? 1'b1 : 1'b0; rw = 1; addr = 30'h5;
      stall = (i >= 2 && i <= 4) ? 1'b1 : 1'b0;
      bi.bus_grnt_ = (i == 1) ? 1'b0 : 1'b1;
      bi.bus_rdy_ = (i == 2) ? 1'b0 : 1'b1;
      bi.bus_rd_data = (i == 2) ? 32'hCAFEF00D : 32'h0;
      @(negedge clk);
      as_cnt += int'(!bi.bus_as_);
      if (i >= 2 && i <= 5) begin
        checks++;
        if (rd_data !== 32'hCAFEF00D || busy !== 1'b0) begin
          errors++; $display("FAIL stall_hold_%0d got rd %h busy %b want cafef00d 0", i, rd_data, busy);
        end
      end
      if (i == 4) begin
        checks++;
        if (bi.bus_req_ !== 1'b1) begin errors++; $display("FAIL stall_no_req got %b want 1", bi.bus_req_); end
      end
      if (i == 6) begin
        checks++;
        if (rd_data !== 32'd0 || busy !== 1'b0) begin
          errors++; $display("FAIL stall_exit got rd %h busy %b want 0 0", rd_data, busy);
        end
      end
      next_cycle();
    end
    checks++;
    if (as_cnt !== 1) begin errors++; $display("FAIL stall_as_cycles got %0d want 1", as_cnt); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 7; i++) begin
      as_ = (i == 6) ? 1'b1 : 1'b0; rw = 1; addr = 30'h7;
      stall = (i == 5) ? 1'b1 : 1'b0;
      bi.bus_grnt_ = (i == 1) ? 1'b0 : 1'b1;
      bi.bus_rdy_ = 1;
      @(negedge clk);
      if (i >= 2 && i <= 4) begin
        checks++;
        if (bus_err !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL tmo_wait_%0d got err %b busy %b want 0 1", i, bus_err, busy);
        end
      end
      if (i == 5) begin
        checks++;
        if (bus_err !== 1'b1 || busy !== 1'b0 || rd_data !== 32'd0) begin
          errors++; $display("FAIL tmo_abort got err %b busy %b rd %h want 1 0 0", bus_err, busy, rd_data);
        end
      end
      if (i == 6) begin
        checks++;
        if (bus_err !== 1'b0 || bi.bus_req_ !== 1'b1 || rd_data !== 32'd0) begin
          errors++; $display("FAIL tmo_after got err %b req_ %b rd %h want 0 1 0", bus_err, bi.bus_req_, rd_data);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_rdy_at_timeout();
    for (int i = 0; i < 7; i++) begin
      as_ = (i == 6) ? 1'b1 : 1'b0; rw = 1; addr = 30'h8; stall = 0;
      bi.bus_grnt_ = (i == 1) ? 1'b0 : 1'b1;
      bi.bus_rdy_ = (i == 5) ? 1'b0 : 1'b1;
      bi.bus_rd_data = (i == 5) ? 32'h0BADCAFE : 32'h0;
      @(negedge clk);
      if (i == 5) begin
        checks++;
        if (bus_err !== 1'b0 || busy !== 1'b0 || rd_data !== 32'h0BADCAFE) begin
          errors++; $display("FAIL rdy_wins got err %b busy %b rd %h want 0 0 0badcafe", bus_err, busy, rd_data);
        end
      end
      if (i == 6) begin
        checks++;
        if (bus_err !== 1'b0 || bi.bus_req_ !== 1'b1) begin
          errors++; $display("FAIL rdy_wins_after got err %b req_ %b want 0 1", bus_err, bi.bus_req_);
        end
      end
      next_cycle();
    end
    bi.bus_rdy_ = 1; bi.bus_rd_data = '0;
  endtask

  task automatic test_flush_req();
    as_ = 0; flush = 1; rw = 1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy got %b want 0", busy); end
    next_cycle();
    flush = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || bi.bus_req_ !== 1'b1) begin
      errors++; $display("FAIL flush_idle_hold got busy %b req_ %b want 1 1", busy, bi.bus_req_);
    end
    next_cycle();
    flush = 1; bi.bus_grnt_ = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || bi.bus_req_ !== 1'b0) begin
      errors++; $display("FAIL flush_req_state got busy %b req_ %b want 1 0", busy, bi.bus_req_);
    end
    next_cycle();
    flush = 0; bi.bus_grnt_ = 1; as_ = 1;
    @(negedge clk);
    checks++;
    if (bi.bus_req_ !== 1'b1 || bi.bus_as_ !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_req_release got req_ %b as_ %b busy %b want 1 1 0", bi.bus_req_, bi.bus_as_, busy);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bi.bus_as_ !== 1'b1) begin errors++; $display("FAIL flush_req_no_as got %b want 1", bi.bus_as_); end
    next_cycle();
  endtask

  task automatic test_flush_access();
    for (int i = 0; i < 6; i++) begin
      as_ = (i >= 4) ? 1'b1 : 1'b0; rw = 1; addr = 30'h9;
      flush = (i == 2 || i == 4) ? 1'b1 : 1'b0;
      stall = (i == 3 || i == 4) ? 1'b1 : 1'b0;
      bi.bus_grnt_ = (i == 1) ? 1'b0 : 1'b1;
      bi.bus_rdy_ = (i == 3) ? 1'b0 : 1'b1;
      bi.bus_rd_data = (i == 3) ? 32'h55AA55AA : 32'h0;
      @(negedge clk);
      if (i == 2) begin
        checks++;
        if (busy !== 1'b1 || bi.bus_req_ !== 1'b0) begin
          errors++; $display("FAIL flush_acc_keep got busy %b req_ %b want 1 0", busy, bi.bus_req_);
        end
      end
      if (i == 3) begin
        checks++;
        if (rd_data !== 32'h55AA55AA || busy !== 1'b0 || bus_err !== 1'b0) begin
          errors++; $display("FAIL flush_acc_done got rd %h busy %b err %b want 55aa55aa 0 0", rd_data, busy, bus_err);
        end
      end
      if (i == 4) begin
        checks++;
        if (rd_data !== 32'h55AA55AA) begin errors++; $display("FAIL flush_acc_latch got %h want 55aa55aa", rd_data); end
      end
      if (i == 5) begin
        checks++;
        if (rd_data !== 32'd0 || busy !== 1'b0) begin
          errors++; $display("FAIL flush_stall_exit got rd %h busy %b want 0 0", rd_data, busy);
        end
      end
      next_cycle();
    end
    flush = 0; stall = 0;
  endtask

  task automatic test_reset_mid();
    as_ = 0; rw = 0; addr = 30'h3FF; wr_data = 32'h0000A5A5; bi.bus_grnt_ = 0;
    next_cycle();
    next_cycle();
    bi.bus_grnt_ = 1;
    @(negedge clk);
    checks++;
    if (bi.bus_as_ !== 1'b0 || bi.bus_req_ !== 1'b0) begin
      errors++; $display("FAIL rst_mid_pre got as_ %b req_ %b want 0 0", bi.bus_as_, bi.bus_req_);
    end
    as_ = 1;
    #2 reset = 1;
    #1;
    checks++;
    if (bi.bus_req_ !== 1'b1 || bi.bus_as_ !== 1'b1 || bi.bus_rw !== 1'b1) begin
      errors++; $display("FAIL rst_mid_strobes got req_ %b as_ %b rw %b want 1 1 1", bi.bus_req_, bi.bus_as_, bi.bus_rw);
    end
    checks++;
    if (bi.bus_addr !== 30'd0 || bi.bus_wr_data !== 32'd0 || bus_err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_cmd got addr %h data %h err %b busy %b want 0 0 0 0",
                         bi.bus_addr, bi.bus_wr_data, bus_err, busy);
    end
    next_cycle();
    reset = 0;
    as_ = 0;
    #1;
    checks++;
    if (busy !== 1'b1 || bi.bus_req_ !== 1'b1) begin
      errors++; $display("FAIL rst_mid_idle got busy %b req_ %b want 1 1", busy, bi.bus_req_);
    end
    as_ = 1;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_stall_hold();
    test_timeout();
    test_rdy_at_timeout();
    test_flush_req();
    test_flush_access();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/yutorina_bus_if.md
YUTORINA_BUS_IF -- requirements
Module: yutorina_bus_if

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, SHALL set the max ACCESS cycles without bus_rdy_ before abort (range 1..255).
REQ-002 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 stall  in  1  pipeline stall; 1 = MEM stage holds its current instruction.
REQ-005 flush  in  1  pipeline flush; 1 = current MEM instruction is cancelled.
REQ-006 as_  in  1  access strobe from the MEM control stage, active-low.
REQ-007 rw  in  1  access direction, 1 = READ, 0 = WRITE.
REQ-008 addr  in  30  word address; byte offset was already checked upstream.
REQ-009 wr_data  in  32  store data.
REQ-010 rd_data  out  32  load data returned to the MEM control stage.
REQ-011 busy  out  1  1 = MEM stage must stall for this access.
REQ-012 bus_err  out  1  one-cycle pulse on bus timeout.
REQ-013 bus_req_  out  1  bus request, active-low.
REQ-014 bus_grnt_  in  1  bus grant, active-low.
REQ-015 bus_as_  out  1  bus address strobe, active-low.
REQ-016 bus_rw / bus_addr / bus_wr_data  out  1/30/32  registered bus command.
REQ-017 bus_rd_data  in  32  bus read data.
REQ-018 bus_rdy_  in  1  bus ready, active-low.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, ACCESS and STALL.
REQ-020 IDLE, with as_=0 and flush=0: the block SHALL assert busy combinationally, register bus_req_=0 and go to REQ; otherwise it SHALL stay in IDLE with busy=0.
REQ-021 REQ: busy SHALL be 1 and bus_req_ SHALL stay 0.
REQ-022 REQ, on bus_grnt_=0: the block SHALL register bus_as_=0, bus_rw=rw, bus_addr=addr and bus_wr_data=wr_data, clear the timeout counter and go to ACCESS.
REQ-023 bus_as_ SHALL be low for exactly the first ACCESS cycle; bus_rw, bus_addr and bus_wr_data SHALL hold until the access ends.
REQ-024 ACCESS with bus_rdy_=1: busy SHALL be 1 and the 8-bit counter SHALL increment.
REQ-025 ACCESS with bus_rdy_=0: busy SHALL be 0 that same cycle and rd_data SHALL equal bus_rd_data combinationally (reads); bus_rd_data SHALL be latched into rd_buf on reads only; bus_req_ SHALL be released to 1; next state SHALL be STALL if stall=1, else IDLE.
REQ-026 ACCESS with counter == TIMEOUT_CYC-1 and bus_rdy_=1: the block SHALL pulse bus_err, set busy=0 and rd_data=0, load rd_buf=0, release bus_req_, and go to STALL/IDLE per stall.
REQ-027 STALL: busy SHALL be 0, rd_data SHALL equal rd_buf and no new bus request SHALL be issued; the block SHALL go to IDLE when stall=0 or flush=1.
REQ-028 IDLE, and REQ without completion: rd_data SHALL be 0.
REQ-029 A flush in REQ SHALL release bus_req_ and return to IDLE; a flush in ACCESS SHALL NOT abort the bus cycle, and the result SHALL still be latched.
REQ-030 bus_rdy_ and timeout in the same cycle: bus_rdy_ SHALL win, with no bus_err.
REQ-031 A grant arriving in the same cycle as flush in REQ SHALL be ignored.

Reset
REQ-032 Reset SHALL set state=IDLE, bus_req_=1, bus_as_=1, bus_rw=READ, bus_addr=0, bus_wr_data=0, rd_buf=0, counter=0 and bus_err=0, with busy=0 while as_=1.
REQ-033 Reset asserted mid-access SHALL immediately return all bus outputs to reset values, with no bus_err.

Verification
REQ-034 Read: as_=0, rw=1, addr=0x10, grant after 1 cycle, rdy_ after 2 cycles, bus_rd_data=0xDEADBEEF -> busy for 4 cycles, rd_data=0xDEADBEEF in the rdy_ cycle, bus_as_ low exactly 1 cycle.
REQ-035 Write: as_=0, rw=0, wr_data=0x12345678, immediate grant and rdy_ -> bus_wr_data=0x12345678, bus_rw=0, rd_buf unchanged.
REQ-036 Stall hold: read completes with stall=1 for 3 cycles -> single bus access, busy=0, rd_data stable from rd_buf; then IDLE.
REQ-037 Timeout: TIMEOUT_CYC=4, bus_rdy_ held 1 -> bus_err pulse on the 4th ACCESS cycle, rd_data=0, bus_req_=1 next cycle.
REQ-038 Flush in REQ -> bus_req_=1 next cycle, no bus_as_; flush in ACCESS -> access completes normally.
REQ-039 Reset pulsed in ACCESS -> bus_req_=1 and bus_as_=1 immediately, state IDLE, no bus_err.
